// File: rtl/bru_pkg.sv
// Purpose : shared types and defaults for the branch resolve unit and its prediction FIFO.
// Latency : n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
// Contents: bru_state_t {IDLE, RECOVER}; pred_entry_t {pc, pred, target, hit};
//           BRU_DEPTH / BRU_RECOVER_CYCLES defaults; seq_pc() fall-through PC helper.
package bru_pkg;

    localparam int BRU_DEPTH          = 4;
    localparam int BRU_RECOVER_CYCLES = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } bru_state_t;

    // One fetch-stage prediction, queued until its instruction reaches execute.
    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] target;
        logic        hit;
    } pred_entry_t;

    // Sequential fall-through address; wraps modulo 2^32.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// Purpose : in-order queue of fetch-stage predictions (DEPTH x pred_entry_t), with a flush-style clear.
// Latency : push visible at head the cycle after the write; head is a combinational read of the oldest entry.
// Backpressure: full when count==DEPTH; a push while full and a pop while empty are ignored.
// Ports   : Clk, Rst (sync, active-high); push/push_entry; pop; clear; head; full; empty.
module pred_fifo
    import bru_pkg::*;
#(
    parameter int DEPTH = BRU_DEPTH
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        push,
    input  pred_entry_t push_entry,
    input  logic        pop,
    input  logic        clear,
    output pred_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pred_entry_t        mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Clear drops every stored entry but keeps a same-cycle push, which is
    // the next instruction from fetch rather than stale state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? PTR_W'(1) : '0;
            count  <= do_push ? CNT_W'(1) : '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; empty gates every use of head.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[clear ? '0 : wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Purpose : checks queued fetch predictions against execute outcomes; drives flush/redirect and predictor update.
// Latency : Flush/RedirectPC/Mispredict/Upd* registered, 1 cycle after E_Valid; Flush held RECOVER_CYCLES cycles.
// Backpressure: F_Stall = prediction FIFO full (from count only); fetch and execute inputs ignored while in RECOVER.
// Ports   : Clk, Rst (sync, active-high); F_* fetch prediction in, F_Stall out; E_* execute outcome in;
//           Flush, RedirectPC, Mispredict recovery out; UpdValid/UpdPC/UpdTarget/UpdTaken predictor update out.
// Config  : define BRU_PERF_CNT_EN to add BranchCount/MispredictCount (wrap at 2^32, cleared by Rst).
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DEPTH          = BRU_DEPTH,
    parameter int RECOVER_CYCLES = BRU_RECOVER_CYCLES
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        F_Valid,
    input  logic [31:0] F_PC,
    input  logic        F_Prediction,
    input  logic [31:0] F_PCPredict,
    input  logic        F_BtbHit,
    output logic        F_Stall,
    input  logic        E_Valid,
    input  logic [31:0] E_PC,
    input  logic        E_Branch,
    input  logic        E_BranchTaken,
    input  logic [31:0] E_PCBranch,
    output logic        Flush,
    output logic [31:0] RedirectPC,
    output logic        Mispredict,
    output logic        UpdValid,
    output logic [31:0] UpdPC,
    output logic [31:0] UpdTarget,
    output logic        UpdTaken
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredictCount
`endif
);

    localparam int RC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    bru_state_t   state;
    logic [RC_W-1:0] rec_cnt;

    pred_entry_t  head;
    pred_entry_t  push_entry;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_clear;

    logic         is_idle;
    logic         resolve;
    logic         head_match;
    logic         pred_taken;
    logic         misp_raw;
    logic         mispredict_now;
    logic [31:0]  redirect_next;
    logic         unused_head_hit;

    assign is_idle    = (state == IDLE);
    assign resolve    = is_idle && E_Valid;
    // A head whose PC differs from execute means the queue lost sync with the
    // pipeline; the instruction is then judged as predicted not-taken.
    assign head_match = !fifo_empty && (head.pc == E_PC);
    assign pred_taken = head_match && head.pred;
    assign unused_head_hit = head.hit;

    always_comb begin
        misp_raw      = 1'b0;
        redirect_next = seq_pc(E_PC);
        if (E_Branch) begin
            if (E_BranchTaken) begin
                redirect_next = E_PCBranch;
                misp_raw      = !pred_taken || (head.target != E_PCBranch);
            end else begin
                misp_raw      = pred_taken;
            end
        end else begin
            // Non-branch hit in the BTB by alias: fall through.
            misp_raw = pred_taken;
        end
    end

    assign mispredict_now = resolve && misp_raw;

    assign push_entry = '{pc: F_PC, pred: F_Prediction, target: F_PCPredict, hit: F_BtbHit};
    assign F_Stall    = fifo_full;
    // Anything fetched alongside a mispredict is wrong-path and is not queued.
    assign fifo_push  = F_Valid && !fifo_full && is_idle && !mispredict_now;
    assign fifo_pop   = resolve && head_match;
    assign fifo_clear = resolve && (!head_match || mispredict_now);

    pred_fifo #(
        .DEPTH(DEPTH)
    ) u_pred_fifo (
        .Clk        (Clk),
        .Rst        (Rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .clear      (fifo_clear),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Flush is high exactly while state==RECOVER; RedirectPC and Upd* hold
    // their last values between events.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            rec_cnt    <= '0;
            Flush      <= 1'b0;
            RedirectPC <= 32'h0;
            Mispredict <= 1'b0;
            UpdValid   <= 1'b0;
            UpdPC      <= 32'h0;
            UpdTarget  <= 32'h0;
            UpdTaken   <= 1'b0;
        end else begin
            Mispredict <= 1'b0;
            UpdValid   <= 1'b0;
            case (state)
                IDLE: begin
                    if (resolve && E_Branch) begin
                        UpdValid  <= 1'b1;
                        UpdPC     <= E_PC;
                        UpdTarget <= E_PCBranch;
                        UpdTaken  <= E_BranchTaken;
                    end
                    if (mispredict_now) begin
                        state      <= RECOVER;
                        Flush      <= 1'b1;
                        Mispredict <= 1'b1;
                        RedirectPC <= redirect_next;
                        rec_cnt    <= RC_W'(RECOVER_CYCLES - 1);
                    end
                end
                RECOVER: begin
                    if (rec_cnt == '0) begin
                        state <= IDLE;
                        Flush <= 1'b0;
                    end else begin
                        rec_cnt <= rec_cnt - RC_W'(1);
                    end
                end
            endcase
        end
    end

`ifdef BRU_PERF_CNT_EN
    // Counters advance on the same edge that raises the matching strobe.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            BranchCount     <= 32'h0;
            MispredictCount <= 32'h0;
        end else begin
            if (resolve && E_Branch) BranchCount     <= BranchCount + 32'd1;
            if (mispredict_now)      MispredictCount <= MispredictCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Purpose : self-checking bench for branch_resolve_unit (directed scenarios, then randomized traffic).
// Latency : expected outputs are compared one cycle after the inputs that produce them.
// Backpressure: F_Stall is compared against the reference queue occupancy every cycle.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;
    localparam int RC    = 2;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        F_Valid = 1'b0;
    logic [31:0] F_PC = 32'h0;
    logic        F_Prediction = 1'b0;
    logic [31:0] F_PCPredict = 32'h0;
    logic        F_BtbHit = 1'b0;
    logic        F_Stall;
    logic        E_Valid = 1'b0;
    logic [31:0] E_PC = 32'h0;
    logic        E_Branch = 1'b0;
    logic        E_BranchTaken = 1'b0;
    logic [31:0] E_PCBranch = 32'h0;
    logic        Flush;
    logic [31:0] RedirectPC;
    logic        Mispredict;
    logic        UpdValid;
    logic [31:0] UpdPC;
    logic [31:0] UpdTarget;
    logic        UpdTaken;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] BranchCount;
    logic [31:0] MispredictCount;
`endif

    always #5 Clk = ~Clk;

    branch_resolve_unit #(.DEPTH(DEPTH), .RECOVER_CYCLES(RC)) dut (
        .Clk(Clk), .Rst(Rst),
        .F_Valid(F_Valid), .F_PC(F_PC), .F_Prediction(F_Prediction),
        .F_PCPredict(F_PCPredict), .F_BtbHit(F_BtbHit), .F_Stall(F_Stall),
        .E_Valid(E_Valid), .E_PC(E_PC), .E_Branch(E_Branch),
        .E_BranchTaken(E_BranchTaken), .E_PCBranch(E_PCBranch),
        .Flush(Flush), .RedirectPC(RedirectPC), .Mispredict(Mispredict),
        .UpdValid(UpdValid), .UpdPC(UpdPC), .UpdTarget(UpdTarget), .UpdTaken(UpdTaken)
`ifdef BRU_PERF_CNT_EN
        , .BranchCount(BranchCount), .MispredictCount(MispredictCount)
`endif
    );

    // Reference model: a queue of outstanding predictions plus a count of
    // remaining flush cycles; cur holds the outputs the DUT should show.
    typedef struct {
        logic [31:0] pc;
        bit          pred;
        logic [31:0] tgt;
    } ent_t;

    typedef struct {
        bit          flush;
        bit          misp;
        bit          upd;
        bit          upd_taken;
        logic [31:0] redir;
        logic [31:0] upd_pc;
        logic [31:0] upd_tgt;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    exp_t cur;
    int   rec_left = 0;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] next_pc = 32'h1000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s actual=%h required=%h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit fv, input logic [31:0] fpc, input bit fpred,
                              input logic [31:0] ftgt, input bit ev, input logic [31:0] epc,
                              input bit ebr, input bit etk, input logic [31:0] epcb);
        bit          full;
        bit          match;
        bit          pred;
        bit          misp;
        logic [31:0] tgt;
        logic [31:0] redir;
        full  = (mq.size() == DEPTH);
        match = 0;
        pred  = 0;
        misp  = 0;
        tgt   = 32'h0;
        redir = 32'h0;
        cur.misp = 0;
        cur.upd  = 0;
        if (rst) begin
            mq.delete();
            rec_left = 0;
            cur = '{flush: 0, misp: 0, upd: 0, upd_taken: 0, redir: 0, upd_pc: 0, upd_tgt: 0, bc: 0, mc: 0};
        end else if (rec_left > 0) begin
            rec_left--;
            cur.flush = (rec_left > 0);
        end else begin
            if (ev) begin
                match = (mq.size() > 0) && (mq[0].pc == epc);
                if (match) begin
                    pred = mq[0].pred;
                    tgt  = mq[0].tgt;
                end
                if (ebr && etk) begin
                    misp  = !pred || (tgt != epcb);
                    redir = epcb;
                end else begin
                    misp  = pred;
                    redir = epc + 32'd4;
                end
                if (ebr) begin
                    cur.upd       = 1;
                    cur.upd_pc    = epc;
                    cur.upd_tgt   = epcb;
                    cur.upd_taken = etk;
                    cur.bc        = cur.bc + 32'd1;
                end
                if (match && !misp) void'(mq.pop_front());
                else mq.delete();
                if (misp) begin
                    rec_left  = RC;
                    cur.flush = 1;
                    cur.misp  = 1;
                    cur.redir = redir;
                    cur.mc    = cur.mc + 32'd1;
                end
            end
            if (fv && !full && !misp) mq.push_back('{pc: fpc, pred: fpred, tgt: ftgt});
        end
        sb.push_back(cur);
    endtask

    task automatic drive(input bit rst, input bit fv, input logic [31:0] fpc, input bit fpred,
                         input logic [31:0] ftgt, input bit ev, input logic [31:0] epc,
                         input bit ebr, input bit etk, input logic [31:0] epcb);
        @(negedge Clk);
        Rst = rst; F_Valid = fv; F_PC = fpc; F_Prediction = fpred; F_PCPredict = ftgt;
        F_BtbHit = fpred; E_Valid = ev; E_PC = epc; E_Branch = ebr; E_BranchTaken = etk;
        E_PCBranch = epcb;
        #1;
        chk("f_stall", {31'h0, F_Stall}, {31'h0, (mq.size() == DEPTH)});
        model_step(rst, fv, fpc, fpred, ftgt, ev, epc, ebr, etk, epcb);
    endtask

    task automatic push(input logic [31:0] pc, input bit pred, input logic [31:0] tgt);
        drive(0, 1, pc, pred, tgt, 0, 0, 0, 0, 0);
    endtask

    task automatic exec(input logic [31:0] pc, input bit br, input bit tk, input logic [31:0] pcb);
        drive(0, 0, 0, 0, 0, 1, pc, br, tk, pcb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares every registered output one cycle after each stimulus cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("flush",      {31'h0, Flush},      {31'h0, e.flush});
                chk("mispredict", {31'h0, Mispredict}, {31'h0, e.misp});
                chk("redirect_pc", RedirectPC, e.redir);
                chk("upd_valid",  {31'h0, UpdValid},   {31'h0, e.upd});
                chk("upd_pc",     UpdPC,               e.upd_pc);
                chk("upd_target", UpdTarget,           e.upd_tgt);
                chk("upd_taken",  {31'h0, UpdTaken},   {31'h0, e.upd_taken});
`ifdef BRU_PERF_CNT_EN
                chk("branch_count",     BranchCount,     e.bc);
                chk("mispredict_count", MispredictCount, e.mc);
`endif
            end
        end
    end

    initial begin
        bit          rst, fv, fpred, ev, ebr, etk;
        logic [31:0] fpc, ftgt, epc, epcb;

        // 1: reset, correct taken prediction
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(32'h40, 1, 32'h80);
        exec(32'h40, 1, 1, 32'h80);
        idle(1);
        // 2: predicted not-taken but taken; fetch during recovery is ignored
        push(32'h44, 0, 32'h0);
        exec(32'h44, 1, 1, 32'h100);
        drive(0, 1, 32'h48, 1, 32'h90, 1, 32'h48, 1, 1, 32'h90);
        drive(0, 1, 32'h4C, 0, 32'h0, 0, 0, 0, 0, 0);
        exec(32'h48, 1, 1, 32'h90);
        idle(3);
        // 3: predicted taken but not taken
        push(32'h48, 1, 32'h90);
        exec(32'h48, 1, 0, 32'h90);
        idle(3);
        // 4: fill to full, dropped push, push while popping at full
        push(32'h60, 0, 0);
        push(32'h64, 0, 0);
        push(32'h68, 0, 0);
        push(32'h6C, 0, 0);
        push(32'h70, 0, 0);
        drive(0, 1, 32'h70, 0, 0, 1, 32'h60, 0, 0, 0);
        drive(0, 1, 32'h70, 0, 0, 1, 32'h64, 1, 0, 32'h0);
        exec(32'h68, 0, 0, 0);
        exec(32'h6C, 0, 0, 0);
        exec(32'h70, 0, 0, 0);
        idle(1);
        // 5: BTB alias on a non-branch, then head PC mismatch clears the queue
        push(32'h50, 1, 32'h200);
        exec(32'h50, 0, 0, 0);
        idle(3);
        push(32'h50, 0, 0);
        push(32'h54, 1, 32'h300);
        exec(32'h58, 1, 0, 0);
        exec(32'h54, 1, 0, 0);
        idle(2);
        // 6: reset during recovery
        push(32'h44, 0, 0);
        exec(32'h44, 1, 1, 32'h300);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Randomized traffic; execute PCs mostly follow the reference queue head.
        for (int n = 0; n < 4000; n++) begin
            rst   = ($urandom_range(0, 299) == 0);
            fv    = ($urandom_range(0, 99) < 60);
            fpc   = next_pc;
            if (fv) next_pc = next_pc + 32'd4;
            fpred = $urandom_range(0, 1);
            ftgt  = {24'h0, 4'($urandom_range(0, 7)), 4'h0};
            ev    = ($urandom_range(0, 99) < 55);
            if (mq.size() > 0 && $urandom_range(0, 99) < 85) epc = mq[0].pc;
            else epc = next_pc - {28'h0, 4'($urandom_range(0, 3)), 2'b00};
            ebr   = ($urandom_range(0, 99) < 70);
            etk   = $urandom_range(0, 1);
            if (mq.size() > 0 && $urandom_range(0, 99) < 60) epcb = mq[0].tgt;
            else epcb = {24'h0, 4'($urandom_range(0, 7)), 4'h0};
            drive(rst, fv, fpc, fpred, ftgt, ev, epc, ebr, etk, epcb);
        end

        idle(4);
        #10;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
